// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receive state encoding
package uart_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int LAST_SAMPLE = 15;
  localparam int DATA_BITS = 8;
  localparam int CLKS_PER_TICK_9600 = 326;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_e;
endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: serial line in, received byte and status strobes out
interface uart_rx_ctrl_if;
  import uart_pkg::*;
  logic rx;
  logic [DATA_BITS-1:0] rx_data;
  logic rx_valid;
  logic frame_err;
  logic busy;
  modport master(input rx, output rx_data, rx_valid, frame_err, busy);
  modport slave(output rx, input rx_data, rx_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx_ctrl_baud_tick_gen.sv
// baud_tick_gen: free-running single-cycle oversample enable every CLKS_PER_TICK clocks
module baud_tick_gen #(
  parameter int CLKS_PER_TICK = 326
) (
  input  logic clk50MHz,
  input  logic reset,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_TICK);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_TICK - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q == LAST;
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk50MHz) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receiver with 16x oversampling, mid-bit sampling and framing check
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = CLKS_PER_TICK_9600
) (
  input logic clk50MHz,
  input logic reset,
  uart_rx_ctrl_if.master bus
);
  rx_state_e state_q, state_d;
  logic sync1_q, sync2_q, rx_s, tick, mid, last;
  logic [3:0] sample_q, sample_d;
  logic [2:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
  baud_tick_gen #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
    .clk50MHz(clk50MHz),
    .reset(reset),
    .tick(tick)
  );
  assign rx_s = sync2_q;
  assign mid = sample_q == 4'(MID_SAMPLE);
  assign last = sample_q == 4'(LAST_SAMPLE);
  always_comb begin
    state_d = state_q;
    sample_d = sample_q;
    bit_d = bit_q;
    shift_d = shift_q;
    data_d = data_q;
    valid_d = 1'b0;
    ferr_d = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          state_d = rx_s ? IDLE : START;
          sample_d = '0;
        end
        START: begin
          state_d = mid ? (rx_s ? IDLE : DATA) : START;
          sample_d = mid ? '0 : sample_q + 4'd1;
          bit_d = mid ? '0 : bit_q;
        end
        DATA: begin
          sample_d = last ? '0 : sample_q + 4'd1;
          shift_d = last ? {rx_s, shift_q[DATA_BITS-1:1]} : shift_q;
          bit_d = last ? (bit_q == 3'(DATA_BITS - 1) ? '0 : bit_q + 3'd1) : bit_q;
          state_d = last && bit_q == 3'(DATA_BITS - 1) ? STOP : DATA;
        end
        STOP: begin
          sample_d = last ? '0 : sample_q + 4'd1;
          state_d = last ? (rx_s ? IDLE : WAIT_HIGH) : STOP;
          data_d = last && rx_s ? shift_q : data_q;
          valid_d = last && rx_s;
          ferr_d = last && !rx_s;
        end
        WAIT_HIGH: state_d = rx_s ? IDLE : WAIT_HIGH;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk50MHz) begin
    if (reset) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sample_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= bus.rx;
      sync2_q <= sync1_q;
      sample_q <= sample_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
    end
  end
  assign bus.rx_data = data_q;
  assign bus.rx_valid = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: randomized serial frames scored against a frame-level receive model
module tb_uart_rx_ctrl;
  import uart_pkg::*;
  localparam int CPT = 4;
  localparam int BIT = CPT * OVERSAMPLE;
  typedef struct {
    logic err;
    logic [7:0] d;
  } ev_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick326;
  logic prev_strobe = 1'b0;
  int total = 0;
  int bad = 0;
  ev_t q[$];
  ev_t e_m;
  logic [7:0] held = 8'h00;
  always #5 clk = ~clk;
  uart_rx_ctrl_if bus();
  uart_rx_ctrl #(.CLKS_PER_TICK(CPT)) dut (
    .clk50MHz(clk),
    .reset(reset),
    .bus(bus)
  );
  baud_tick_gen #(.CLKS_PER_TICK(326)) u_t326 (
    .clk50MHz(clk),
    .reset(reset),
    .tick(tick326)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic bit_time(input logic v);
    bus.rx = v;
    repeat (BIT) @(posedge clk);
  endtask
  task automatic send(input logic [7:0] b, input int low_stop);
    q.push_back(ev_t'{err: low_stop != 0, d: low_stop != 0 ? held : b});
    if (low_stop == 0) held = b;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) begin
      bit_time(b[i]);
      if (i == 1) begin
        #1 chk("busy_mid_frame", 32'(bus.busy), 1);
      end
    end
    if (low_stop != 0) begin
      bus.rx = 1'b0;
      repeat (low_stop * BIT) @(posedge clk);
      #1 chk("busy_wait_high", 32'(bus.busy), 1);
    end
    bit_time(1'b1);
    #1 chk("busy_after_frame", 32'(bus.busy), 0);
  endtask
  task automatic tick_gap(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dut.u_tick.tick && n < 50);
  endtask
  always @(negedge clk) begin
    if (prev_strobe) chk("strobe_width", 32'(bus.rx_valid | bus.frame_err), 0);
    if (bus.rx_valid | bus.frame_err) begin
      chk("strobe_exclusive", 32'(bus.rx_valid & bus.frame_err), 0);
      chk("busy_at_strobe", 32'(bus.busy), 32'(bus.frame_err));
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got valid=%b err=%b data=%h expected none", bus.rx_valid, bus.frame_err, bus.rx_data);
      end else begin
        e_m = q.pop_front();
        chk("strobe_kind", 32'(bus.frame_err), 32'(e_m.err));
        chk("rx_data", 32'(bus.rx_data), 32'(e_m.d));
      end
    end
    prev_strobe <= bus.rx_valid | bus.frame_err;
  end
  initial begin
    #3ms;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rx_data", 32'(bus.rx_data), 0);
    chk("reset_rx_valid", 32'(bus.rx_valid), 0);
    chk("reset_frame_err", 32'(bus.frame_err), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    reset = 1'b0;
    tick_gap(n);
    chk("first_tick_edge", 32'(n + 1), 4);
    tick_gap(n);
    chk("tick_spacing_a", 32'(n), CPT);
    tick_gap(n);
    chk("tick_spacing_b", 32'(n), CPT);
    n = 0;
    while (!tick326 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick326 && n < 1000);
    chk("tick_spacing_326", 32'(n), 326);
    @(posedge clk);
    send(8'hA5, 0);
    bus.rx = 1'b0;
    repeat (4 * CPT) @(posedge clk);
    #1 chk("glitch_busy_high", 32'(bus.busy), 1);
    bus.rx = 1'b1;
    repeat (12 * CPT) @(posedge clk);
    #1 chk("glitch_busy_low", 32'(bus.busy), 0);
    chk("glitch_rx_data", 32'(bus.rx_data), 32'(held));
    send(8'h3C, 3);
    send(8'h00, 0);
    send(8'hFF, 0);
    bit_time(1'b1);
    bus.rx = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 3; i++) bit_time(1'(8'h55 >> i));
    bus.rx = 1'b1;
    repeat (BIT / 2) @(posedge clk);
    reset = 1'b1;
    @(posedge clk);
    reset = 1'b0;
    held = 8'h00;
    #1 chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_rx_data", 32'(bus.rx_data), 0);
    repeat (2 * BIT) @(posedge clk);
    send(8'h81, 0);
    for (int k = 0; k < 30; k++) begin
      send(8'($urandom), ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0);
      bus.rx = 1'b1;
      repeat ($urandom_range(0, 2 * BIT)) @(posedge clk);
    end
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("pending_events", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side UART controller for the Ball Plate servo link: turns the serial line from the host into bytes for the servo command decoder.
- Runs off the DE0-Nano 50 MHz crystal; derives a 16x-oversample tick enable (9600 baud x 16) and uses it to sequence start detection, mid-bit sampling and 8N1 framing.
- Emits one byte per frame with a single-cycle valid strobe, or a framing-error strobe.

Parameters:
- CLKS_PER_TICK, 326, clk50MHz cycles per oversample tick (50e6/9600/16, rounded); must be >= 2.
- OVERSAMPLE, 16, ticks per bit.
- DATA_BITS, 8, data bits per frame, LSB first.

Ports:
- clk50MHz  in  1  system clock, 50 MHz; only clock in the block.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input, idle high.
- rx_data  out  8  last good received byte; holds until the next good frame.
- rx_valid  out  1  one-cycle strobe, rx_data updated this cycle.
- frame_err  out  1  one-cycle strobe, stop bit sampled low.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, busy=0, state=IDLE, tick counter=0, both synchroniser flops=1.
- Reset mid-frame aborts the frame with no strobe; the block returns to IDLE.
- Input synchroniser: 2 flops on rx. All decisions use the synchronised value rx_s.
- Tick generator:
  - Counter runs 0..CLKS_PER_TICK-1, then wraps to 0; it is free-running and never restarted by frames.
  - tick is high for exactly one cycle when count == CLKS_PER_TICK-1.
- State is held between ticks. FSM transitions only on cycles where tick=1:
  - IDLE: rx_s==0 -> START, sample_cnt=0.
  - START: sample_cnt increments.
    - At sample_cnt==7 (mid start bit), rx_s==0 -> DATA, sample_cnt=0, bit_idx=0.
    - At sample_cnt==7, rx_s==1 -> IDLE. This is glitch rejection; no strobe.
  - DATA: sample_cnt increments.
    - At sample_cnt==15: shift register <= {rx_s, shift[7:1]} (LSB first), sample_cnt=0, bit_idx increments.
    - After bit_idx 7 is sampled -> STOP.
  - STOP: at sample_cnt==15:
    - rx_s==1 -> rx_data<=shift, rx_valid=1, then IDLE.
    - rx_s==0 -> frame_err=1, rx_data unchanged, then WAIT_HIGH.
  - WAIT_HIGH: stay until a tick with rx_s==1, then IDLE. This prevents a break or stuck-low line from being read as repeated start bits.
- Strobes are registered: high in the clk50MHz cycle after the deciding tick, low the cycle after that. rx_valid and frame_err are never high together.
- Latency:
  - Start confirmation is 8 ticks after the first low-sampled tick.
  - Stop sampling is 8+16*9 = 152 ticks after that first tick.
  - Plus the 2-cycle synchroniser and 1-cycle output register.
- Back-to-back frames: IDLE is re-entered at the stop-bit midpoint, so a start edge arriving half a bit later is caught. No dead time beyond that.
- Counter widths: tick counter is ceil(log2(CLKS_PER_TICK)) bits, sample_cnt 4 bits, bit_idx 3 bits. All counters use explicit compares; none rely on overflow wrap.
- busy is combinational from state; in the cycle a frame completes it drops together with the strobe.

Decomposition:
- Shared package uart_pkg:
  - State enum {IDLE, START, DATA, STOP, WAIT_HIGH}.
  - Constants OVERSAMPLE=16, MID_SAMPLE=7, LAST_SAMPLE=15, DATA_BITS=8, CLKS_PER_TICK_9600=326.
  - The package is reused by the future TX side.
- One sub-module: baud_tick_gen (CLKS_PER_TICK parameter; clk50MHz, reset in; tick out).
  - It is shared with the planned uart_tx_ctrl.
  - It produces an enable, not a derived clock.

Test Plan:
- Send 0xA5 at 9600 8N1 (bit = 16 ticks) -> exactly one rx_valid pulse, rx_data=0xA5, frame_err never high, busy high from start detection to the strobe.
- Pull rx low for 4 ticks, then high -> busy pulses then returns 0, no rx_valid or frame_err, rx_data unchanged.
- Send 0x3C with the stop bit held low for 3 bit times -> one frame_err pulse, no rx_valid, rx_data keeps its previous value, busy stays high until rx returns high.
- Send 0x00 then 0xFF back-to-back with zero idle -> two rx_valid pulses, rx_data=0x00 then 0xFF.
- Assert reset for 1 cycle in the middle of bit 3 of 0x55, then send 0x81 -> no strobe for the aborted frame, next strobe carries rx_data=0x81.
- Use CLKS_PER_TICK=4 for the simulation speed-up; check tick spacing -> tick every 4 cycles, first tick 4 cycles after reset release. With 326, measure 326-cycle spacing.
